// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: architectural widths, the operand-fetch
// slot layout and the operand-resolution helper.
package riscv_pkg;

  localparam int XLEN         = 32;
  localparam int NB_REGS      = 5;
  localparam int NB_ARCH_REGS = 32;
  localparam int UOP_W        = 64;

  typedef struct packed {
    logic               rd_v;
    logic [NB_REGS-1:0] rd_adr;
    logic [XLEN-1:0]    pc;
    logic [UOP_W-1:0]   uop;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
  } opfetch_slot_t;

  // x0 reads as zero, then the same-cycle writeback wins over the register file.
  function automatic logic [XLEN-1:0] resolve_operand(
    input logic               used,
    input logic [NB_REGS-1:0] adr,
    input logic               wb_valid,
    input logic [NB_REGS-1:0] wb_adr,
    input logic [XLEN-1:0]    wb_data,
    input logic [XLEN-1:0]    rf_data
  );
    if (!used || adr == '0)               return '0;
    else if (wb_valid && wb_adr == adr)   return wb_data;
    else                                  return rf_data;
  endfunction

endpackage

// File: rtl/opfetch_scoreboard.sv
// Pending-destination scoreboard for long-latency results; flags RAW/WAW
// hazards for the instruction currently in decode.
module opfetch_scoreboard
  import riscv_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               rs1_v,
  input  logic [NB_REGS-1:0] rs1_adr,
  input  logic               rs2_v,
  input  logic [NB_REGS-1:0] rs2_adr,
  input  logic               rd_v,
  input  logic [NB_REGS-1:0] rd_adr,
  input  logic               set_en,
  input  logic [NB_REGS-1:0] set_adr,
  input  logic               wb_valid,
  input  logic               wb_long,
  input  logic [NB_REGS-1:0] wb_adr,
  output logic               hazard_rs1,
  output logic               hazard_rs2,
  output logic               hazard_rd
);

  logic [NB_ARCH_REGS-1:1] pending;
  logic [NB_ARCH_REGS-1:0] clr_vec;
  logic [NB_ARCH_REGS-1:0] set_vec;
  logic [NB_ARCH_REGS-1:0] busy;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    if (wb_valid && wb_long) clr_vec[wb_adr] = 1'b1;
    if (set_en)              set_vec[set_adr] = 1'b1;
    // A register being retired this cycle is served by the bypass, not stalled on.
    busy = {pending, 1'b0} & ~clr_vec;
  end

  assign hazard_rs1 = rs1_v & busy[rs1_adr];
  assign hazard_rs2 = rs2_v & busy[rs2_adr];
  assign hazard_rd  = rd_v  & busy[rd_adr];

  // NOTE: sequential state uses non-blocking assignments only.
  // Set is applied after clear so a same-cycle set/clear on one register leaves it pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending <= '0;
    else          pending <= (pending & ~clr_vec[NB_ARCH_REGS-1:1]) | set_vec[NB_ARCH_REGS-1:1];
  end

endmodule

// File: rtl/operand_fetch.sv
// Issue/operand-fetch stage: reads the register file, bypasses writeback,
// stalls on scoreboard hazards and hands a registered slot to execute.
module operand_fetch
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush_i,
  input  logic               dec_valid_i,
  output logic               dec_ready_o,
  input  logic               dec_rs1_v_i,
  input  logic               dec_rs2_v_i,
  input  logic [NB_REGS-1:0] dec_rs1_adr_i,
  input  logic [NB_REGS-1:0] dec_rs2_adr_i,
  input  logic               dec_rd_v_i,
  input  logic [NB_REGS-1:0] dec_rd_adr_i,
  input  logic               dec_rd_long_i,
  input  logic [XLEN-1:0]    dec_pc_i,
  input  logic [UOP_W-1:0]   dec_uop_i,
  output logic               rf_rs1_v_o,
  output logic               rf_rs2_v_o,
  output logic [NB_REGS-1:0] rf_rs1_adr_o,
  output logic [NB_REGS-1:0] rf_rs2_adr_o,
  input  logic [XLEN-1:0]    rf_rs1_data_i,
  input  logic [XLEN-1:0]    rf_rs2_data_i,
  input  logic               wb_valid_i,
  input  logic [NB_REGS-1:0] wb_adr_i,
  input  logic [XLEN-1:0]    wb_data_i,
  input  logic               wb_long_i,
  output logic               exe_valid_o,
  input  logic               exe_ready_i,
  output logic [XLEN-1:0]    exe_rs1_data_o,
  output logic [XLEN-1:0]    exe_rs2_data_o,
  output logic               exe_rd_v_o,
  output logic [NB_REGS-1:0] exe_rd_adr_o,
  output logic [XLEN-1:0]    exe_pc_o,
  output logic [UOP_W-1:0]   exe_uop_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  logic          hazard_rs1, hazard_rs2, hazard_rd, hazard;
  logic          slot_free, transfer, set_en;
  logic          exe_valid_q;
  opfetch_slot_t slot_q, slot_d;
  logic [CNT_W-1:0] stall_cnt_q;

  assign rf_rs1_v_o   = dec_rs1_v_i & dec_valid_i;
  assign rf_rs2_v_o   = dec_rs2_v_i & dec_valid_i;
  assign rf_rs1_adr_o = dec_rs1_adr_i;
  assign rf_rs2_adr_o = dec_rs2_adr_i;

  assign set_en = transfer & dec_rd_v_i & dec_rd_long_i & (dec_rd_adr_i != '0);

  opfetch_scoreboard u_scoreboard (
    .clk        (clk),
    .reset_n    (reset_n),
    .rs1_v      (dec_rs1_v_i),
    .rs1_adr    (dec_rs1_adr_i),
    .rs2_v      (dec_rs2_v_i),
    .rs2_adr    (dec_rs2_adr_i),
    .rd_v       (dec_rd_v_i),
    .rd_adr     (dec_rd_adr_i),
    .set_en     (set_en),
    .set_adr    (dec_rd_adr_i),
    .wb_valid   (wb_valid_i),
    .wb_long    (wb_long_i),
    .wb_adr     (wb_adr_i),
    .hazard_rs1 (hazard_rs1),
    .hazard_rs2 (hazard_rs2),
    .hazard_rd  (hazard_rd)
  );

  assign hazard      = hazard_rs1 | hazard_rs2 | hazard_rd;
  assign slot_free   = ~exe_valid_q | exe_ready_i;
  assign dec_ready_o = ~hazard & slot_free & ~flush_i;
  assign transfer    = dec_valid_i & dec_ready_o;

  always_comb begin
    slot_d.rd_v     = dec_rd_v_i;
    slot_d.rd_adr   = dec_rd_v_i ? dec_rd_adr_i : '0;
    slot_d.pc       = dec_pc_i;
    slot_d.uop      = dec_uop_i;
    slot_d.rs1_data = resolve_operand(dec_rs1_v_i, dec_rs1_adr_i, wb_valid_i,
                                      wb_adr_i, wb_data_i, rf_rs1_data_i);
    slot_d.rs2_data = resolve_operand(dec_rs2_v_i, dec_rs2_adr_i, wb_valid_i,
                                      wb_adr_i, wb_data_i, rf_rs2_data_i);
  end

  // Flush blocks transfer through dec_ready_o, so it only needs to drop the valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exe_valid_q <= 1'b0;
      slot_q      <= '0;
    end else if (flush_i) begin
      exe_valid_q <= 1'b0;
    end else if (transfer) begin
      exe_valid_q <= 1'b1;
      slot_q      <= slot_d;
    end else if (exe_ready_i) begin
      exe_valid_q <= 1'b0;
    end
  end

  // Only hazard stalls are counted; pure backpressure is not.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cnt_q <= '0;
    else if (dec_valid_i && hazard && !flush_i && stall_cnt_q != '1)
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign exe_valid_o    = exe_valid_q;
  assign exe_rs1_data_o = slot_q.rs1_data;
  assign exe_rs2_data_o = slot_q.rs2_data;
  assign exe_rd_v_o     = slot_q.rd_v;
  assign exe_rd_adr_o   = slot_q.rd_adr;
  assign exe_pc_o       = slot_q.pc;
  assign exe_uop_o      = slot_q.uop;
  assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a behavioural model checked every cycle
// plus hand-computed expectations for each scenario.
module tb_operand_fetch;
  import riscv_pkg::*;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               flush_i;
  logic               dec_valid_i, dec_ready_o;
  logic               dec_rs1_v_i, dec_rs2_v_i;
  logic [NB_REGS-1:0] dec_rs1_adr_i, dec_rs2_adr_i;
  logic               dec_rd_v_i, dec_rd_long_i;
  logic [NB_REGS-1:0] dec_rd_adr_i;
  logic [XLEN-1:0]    dec_pc_i;
  logic [UOP_W-1:0]   dec_uop_i;
  logic               rf_rs1_v_o, rf_rs2_v_o;
  logic [NB_REGS-1:0] rf_rs1_adr_o, rf_rs2_adr_o;
  logic [XLEN-1:0]    rf_rs1_data_i, rf_rs2_data_i;
  logic               wb_valid_i, wb_long_i;
  logic [NB_REGS-1:0] wb_adr_i;
  logic [XLEN-1:0]    wb_data_i;
  logic               exe_valid_o, exe_ready_i;
  logic [XLEN-1:0]    exe_rs1_data_o, exe_rs2_data_o;
  logic               exe_rd_v_o;
  logic [NB_REGS-1:0] exe_rd_adr_o;
  logic [XLEN-1:0]    exe_pc_o;
  logic [UOP_W-1:0]   exe_uop_o;
  logic [31:0]        stall_cnt_o;

  int checks = 0;
  int errors = 0;

  operand_fetch #(.CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .flush_i(flush_i),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_rs1_v_i(dec_rs1_v_i), .dec_rs2_v_i(dec_rs2_v_i),
    .dec_rs1_adr_i(dec_rs1_adr_i), .dec_rs2_adr_i(dec_rs2_adr_i),
    .dec_rd_v_i(dec_rd_v_i), .dec_rd_adr_i(dec_rd_adr_i), .dec_rd_long_i(dec_rd_long_i),
    .dec_pc_i(dec_pc_i), .dec_uop_i(dec_uop_i),
    .rf_rs1_v_o(rf_rs1_v_o), .rf_rs2_v_o(rf_rs2_v_o),
    .rf_rs1_adr_o(rf_rs1_adr_o), .rf_rs2_adr_o(rf_rs2_adr_o),
    .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
    .wb_valid_i(wb_valid_i), .wb_adr_i(wb_adr_i), .wb_data_i(wb_data_i), .wb_long_i(wb_long_i),
    .exe_valid_o(exe_valid_o), .exe_ready_i(exe_ready_i),
    .exe_rs1_data_o(exe_rs1_data_o), .exe_rs2_data_o(exe_rs2_data_o),
    .exe_rd_v_o(exe_rd_v_o), .exe_rd_adr_o(exe_rd_adr_o),
    .exe_pc_o(exe_pc_o), .exe_uop_o(exe_uop_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_pend [32];
  bit          m_valid;
  logic [31:0] m_rs1, m_rs2, m_pc;
  logic [63:0] m_uop;
  bit          m_rd_v;
  logic [4:0]  m_rd;
  logic [31:0] m_cnt;

  function automatic bit m_busy(input logic [4:0] adr);
    if (adr == 0 || !m_pend[adr]) return 1'b0;
    return !(wb_valid_i && wb_long_i && wb_adr_i == adr);
  endfunction

  function automatic bit m_hazard();
    return (dec_rs1_v_i && m_busy(dec_rs1_adr_i)) ||
           (dec_rs2_v_i && m_busy(dec_rs2_adr_i)) ||
           (dec_rd_v_i  && m_busy(dec_rd_adr_i));
  endfunction

  function automatic bit m_ready();
    return !m_hazard() && (!m_valid || exe_ready_i) && !flush_i;
  endfunction

  function automatic logic [31:0] m_opnd(input bit used, input logic [4:0] adr, input logic [31:0] rf);
    if (!used) return 32'h0;
    if (adr == 0) return 32'h0;
    if (wb_valid_i && wb_adr_i == adr) return wb_data_i;
    return rf;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_pc = 0; m_uop = 0;
      m_rd_v = 0; m_rd = 0; m_cnt = 0;
    end else begin
      bit acc;
      bit hz;
      acc = dec_valid_i && m_ready();
      hz  = m_hazard();
      if (dec_valid_i && hz && !flush_i && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (flush_i) m_valid = 0;
      else if (acc) begin
        m_valid = 1;
        m_rs1 = m_opnd(dec_rs1_v_i, dec_rs1_adr_i, rf_rs1_data_i);
        m_rs2 = m_opnd(dec_rs2_v_i, dec_rs2_adr_i, rf_rs2_data_i);
        m_pc = dec_pc_i; m_uop = dec_uop_i;
        m_rd_v = dec_rd_v_i; m_rd = dec_rd_v_i ? dec_rd_adr_i : 5'd0;
      end else if (exe_ready_i) m_valid = 0;
      if (wb_valid_i && wb_long_i) m_pend[wb_adr_i] = 1'b0;
      if (acc && dec_rd_v_i && dec_rd_long_i && dec_rd_adr_i != 0) m_pend[dec_rd_adr_i] = 1'b1;
    end
  end

  // Compare process: every falling edge while out of reset.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      check("m_dec_ready", dec_ready_o, m_ready());
      check("m_rf_rs1_v", rf_rs1_v_o, dec_rs1_v_i & dec_valid_i);
      check("m_rf_rs2_v", rf_rs2_v_o, dec_rs2_v_i & dec_valid_i);
      check("m_rf_rs1_adr", rf_rs1_adr_o, dec_rs1_adr_i);
      check("m_rf_rs2_adr", rf_rs2_adr_o, dec_rs2_adr_i);
      check("m_exe_valid", exe_valid_o, m_valid);
      check("m_stall_cnt", stall_cnt_o, m_cnt);
      if (m_valid) begin
        check("m_exe_rs1", exe_rs1_data_o, m_rs1);
        check("m_exe_rs2", exe_rs2_data_o, m_rs2);
        check("m_exe_rd_v", exe_rd_v_o, m_rd_v);
        check("m_exe_rd_adr", exe_rd_adr_o, m_rd);
        check("m_exe_pc", exe_pc_o, m_pc);
        check("m_exe_uop", exe_uop_o, m_uop);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    flush_i = 0; dec_valid_i = 0;
    dec_rs1_v_i = 0; dec_rs2_v_i = 0; dec_rs1_adr_i = 0; dec_rs2_adr_i = 0;
    dec_rd_v_i = 0; dec_rd_adr_i = 0; dec_rd_long_i = 0;
    dec_pc_i = 0; dec_uop_i = 0;
    rf_rs1_data_i = 0; rf_rs2_data_i = 0;
    wb_valid_i = 0; wb_adr_i = 0; wb_data_i = 0; wb_long_i = 0;
    exe_ready_i = 1;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic dec(input logic [31:0] pc, input bit r1v, input logic [4:0] r1,
                     input bit r2v, input logic [4:0] r2,
                     input bit rdv, input logic [4:0] rd, input bit lng);
    dec_valid_i = 1; dec_pc_i = pc; dec_uop_i = {32'hC0DE_0000, pc};
    dec_rs1_v_i = r1v; dec_rs1_adr_i = r1; dec_rs2_v_i = r2v; dec_rs2_adr_i = r2;
    dec_rd_v_i = rdv; dec_rd_adr_i = rd; dec_rd_long_i = lng;
  endtask

  task automatic wb(input logic [4:0] adr, input logic [31:0] data, input bit lng);
    wb_valid_i = 1; wb_adr_i = adr; wb_data_i = data; wb_long_i = lng;
  endtask

  initial begin
    idle();
    reset_n = 0;
    #12 reset_n = 1;
    @(negedge clk);
    check("reset_exe_valid", exe_valid_o, 0);
    check("reset_stall_cnt", stall_cnt_o, 0);
    check("reset_exe_pc", exe_pc_o, 0);
    check("reset_dec_ready", dec_ready_o, 1);

    // Bypass: rf returns 0, writeback supplies x5.
    next();
    dec(32'h100, 1, 5, 0, 0, 1, 1, 0);
    wb(5, 32'hDEAD_BEEF, 0);
    next(); idle();
    @(negedge clk);
    check("bypass_valid", exe_valid_o, 1);
    check("bypass_rs1", exe_rs1_data_o, 32'hDEAD_BEEF);
    check("bypass_rd_adr", exe_rd_adr_o, 1);

    // x0 and unused source read as zero; rd_adr zeroed when rd_v=0.
    next();
    dec(32'h104, 0, 3, 1, 0, 0, 9, 0);
    rf_rs1_data_i = 32'hAAAA; rf_rs2_data_i = 32'h1234;
    wb(0, 32'hFF, 0);
    next(); idle();
    @(negedge clk);
    check("x0_rs2", exe_rs2_data_o, 0);
    check("unused_rs1", exe_rs1_data_o, 0);
    check("rd_adr_zeroed", exe_rd_adr_o, 0);

    // Load-use on x7.
    next();
    dec(32'h200, 0, 0, 0, 0, 1, 7, 1);
    next();
    dec(32'h204, 1, 7, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("lu_stall_ready", dec_ready_o, 0);
    check("lu_cnt0", stall_cnt_o, 0);
    next();
    @(negedge clk);
    check("lu_cnt1", stall_cnt_o, 1);
    next();
    wb(7, 32'h55, 1);
    @(negedge clk);
    check("lu_release_ready", dec_ready_o, 1);
    check("lu_cnt2", stall_cnt_o, 2);
    next(); idle();
    @(negedge clk);
    check("lu_rs1", exe_rs1_data_o, 32'h55);
    check("lu_pc", exe_pc_o, 32'h204);
    check("lu_cnt_hold", stall_cnt_o, 2);

    // WAW on x9 and same-cycle set/clear.
    next();
    dec(32'h300, 0, 0, 0, 0, 1, 9, 1);
    next();
    dec(32'h304, 0, 0, 0, 0, 1, 9, 1);
    @(negedge clk);
    check("waw_stall", dec_ready_o, 0);
    next();
    wb(9, 32'h77, 1);
    @(negedge clk);
    check("waw_release", dec_ready_o, 1);
    check("waw_cnt", stall_cnt_o, 3);
    next(); idle();
    dec(32'h308, 0, 0, 1, 9, 0, 0, 0);
    @(negedge clk);
    check("waw_still_pending", dec_ready_o, 0);
    next();
    wb(9, 32'h99, 1);
    @(negedge clk);
    check("waw_clear_ready", dec_ready_o, 1);
    next(); idle();
    @(negedge clk);
    check("waw_rs2", exe_rs2_data_o, 32'h99);
    check("waw_cnt2", stall_cnt_o, 4);

    // Backpressure: slot holds, no stall counted.
    next();
    dec(32'h500, 1, 1, 0, 0, 0, 0, 0);
    rf_rs1_data_i = 32'h11;
    exe_ready_i = 0;
    next();
    dec(32'h600, 1, 2, 0, 0, 0, 0, 0);
    rf_rs1_data_i = 32'h22;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready", dec_ready_o, 0);
      check("bp_valid", exe_valid_o, 1);
      check("bp_pc", exe_pc_o, 32'h500);
      check("bp_rs1", exe_rs1_data_o, 32'h11);
      check("bp_cnt", stall_cnt_o, 4);
      next();
    end
    exe_ready_i = 1;
    @(negedge clk);
    check("bp_release", dec_ready_o, 1);
    next(); idle();
    @(negedge clk);
    check("bp_new_pc", exe_pc_o, 32'h600);

    // Flush keeps the scoreboard; async reset mid-stall clears everything.
    next();
    dec(32'h700, 0, 0, 0, 0, 1, 12, 1);
    next(); idle();
    exe_ready_i = 0; flush_i = 1;
    dec(32'h704, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("flush_ready", dec_ready_o, 0);
    next(); idle();
    @(negedge clk);
    check("flush_valid", exe_valid_o, 0);
    next();
    exe_ready_i = 0;
    dec(32'h708, 0, 0, 0, 0, 0, 0, 0);
    next();
    dec(32'h70C, 1, 12, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("flush_sb_kept", dec_ready_o, 0);
    next();
    @(negedge clk);
    check("pre_reset_valid", exe_valid_o, 1);
    check("pre_reset_cnt", stall_cnt_o, 5);
    #2 reset_n = 0;
    #1;
    check("rst_exe_valid", exe_valid_o, 0);
    check("rst_stall_cnt", stall_cnt_o, 0);
    check("rst_exe_pc", exe_pc_o, 0);
    exe_ready_i = 1;
    #3 reset_n = 1;
    @(negedge clk);
    check("rst_sb_cleared", dec_ready_o, 1);
    next(); idle();
    @(negedge clk);
    check("post_rst_pc", exe_pc_o, 32'h70C);
    repeat (2) next();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
